// File: rtl/hazard_ctl_if.sv
// Decode/stall/forward bundle between the rv32 pipeline stages and hazard_ctl.
// The master side is the pipeline (decode + execute); the slave side is the hazard controller.
interface hazard_ctl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_rd_wen;
    logic              id_is_load;
    logic              ex_br_taken;
    logic              cnt_clr;
    logic              stall_fd;
    logic              flush_fd;
    logic              flush_de;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_wen, id_is_load, ex_br_taken, cnt_clr,
        input  stall_fd, flush_fd, flush_de, fwd_a_sel, fwd_b_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_wen, id_is_load, ex_br_taken, cnt_clr,
        output stall_fd, flush_fd, flush_de, fwd_a_sel, fwd_b_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_ctl.sv
// RAW hazard controller for the 5-stage rv32 core: EX/MEM/WB destination scoreboard,
// stall/flush generation and saturating stall counter. HAZARD_FWD_EN enables operand forwarding.
module hazard_ctl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic         clk,
    input logic         rst,
    hazard_ctl_if.slave bus
);

    logic              ex_v,  mem_v,  wb_v;
    logic              ex_wen, mem_wen, wb_wen;
    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
    logic [CNT_W-1:0]  cnt_q;

    logic rs1_ex, rs1_mem, rs1_wb;
    logic rs2_ex, rs2_mem, rs2_wb;
    logic hazard;
    logic stall;
    logic flush_de;

    function automatic logic hit(
        input logic              ev,
        input logic              ewen,
        input logic [REG_AW-1:0] erd,
        input logic              used,
        input logic [REG_AW-1:0] src
    );
        return ev & ewen & (erd != '0) & used & (src == erd);
    endfunction

    always_comb begin
        rs1_ex  = hit(ex_v,  ex_wen,  ex_rd,  bus.id_rs1_used, bus.id_rs1);
        rs1_mem = hit(mem_v, mem_wen, mem_rd, bus.id_rs1_used, bus.id_rs1);
        rs1_wb  = hit(wb_v,  wb_wen,  wb_rd,  bus.id_rs1_used, bus.id_rs1);
        rs2_ex  = hit(ex_v,  ex_wen,  ex_rd,  bus.id_rs2_used, bus.id_rs2);
        rs2_mem = hit(mem_v, mem_wen, mem_rd, bus.id_rs2_used, bus.id_rs2);
        rs2_wb  = hit(wb_v,  wb_wen,  wb_rd,  bus.id_rs2_used, bus.id_rs2);
    end

`ifdef HAZARD_FWD_EN
    logic              ex_ld;
    logic [1:0]        fwd_a_q, fwd_b_q;
    logic              wbl_v;
    logic [REG_AW-1:0] wbl_rd;

    function automatic logic [1:0] pick(input logic e, input logic m, input logic w);
        if (e)      return 2'b01;
        else if (m) return 2'b10;
        else if (w) return 2'b11;
        else        return 2'b00;
    endfunction

    // Only a load still in EX cannot be forwarded in time.
    assign hazard = ex_ld & (rs1_ex | rs2_ex);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ld   <= 1'b0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
            wbl_v   <= 1'b0;
            wbl_rd  <= '0;
        end else begin
            ex_ld <= bus.id_is_load;
            if (!flush_de && bus.id_valid) begin
                fwd_a_q <= pick(rs1_ex, rs1_mem, rs1_wb);
                fwd_b_q <= pick(rs2_ex, rs2_mem, rs2_wb);
            end else begin
                fwd_a_q <= 2'b00;
                fwd_b_q <= 2'b00;
            end
            if (wb_v && wb_wen && (wb_rd != '0)) begin
                wbl_v  <= 1'b1;
                wbl_rd <= wb_rd;
            end
        end
    end

    // A WB-latch select is only meaningful once a retired write has been captured.
    a_wbl_loaded: assert property (@(posedge clk) disable iff (rst)
        ((fwd_a_q == 2'b11) || (fwd_b_q == 2'b11)) |-> (wbl_v && (wbl_rd != '0)));

    assign bus.fwd_a_sel = fwd_a_q;
    assign bus.fwd_b_sel = fwd_b_q;
`else
    assign hazard = rs1_ex | rs1_mem | rs1_wb | rs2_ex | rs2_mem | rs2_wb;

    assign bus.fwd_a_sel = 2'b00;
    assign bus.fwd_b_sel = 2'b00;
`endif

    assign stall    = bus.id_valid & hazard & ~bus.ex_br_taken;
    assign flush_de = stall | bus.ex_br_taken;

    assign bus.stall_fd  = stall;
    assign bus.flush_fd  = bus.ex_br_taken;
    assign bus.flush_de  = flush_de;
    assign bus.stall_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v    <= 1'b0;
            mem_v   <= 1'b0;
            wb_v    <= 1'b0;
            ex_wen  <= 1'b0;
            mem_wen <= 1'b0;
            wb_wen  <= 1'b0;
            ex_rd   <= '0;
            mem_rd  <= '0;
            wb_rd   <= '0;
        end else begin
            wb_v    <= mem_v;
            wb_wen  <= mem_wen;
            wb_rd   <= mem_rd;
            mem_v   <= ex_v;
            mem_wen <= ex_wen;
            mem_rd  <= ex_rd;
            ex_v    <= bus.id_valid & ~flush_de;
            ex_wen  <= bus.id_rd_wen;
            ex_rd   <= bus.id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard bench for hazard_ctl: directed decode vectors push expected outputs,
// a negedge monitor pops and compares. Expectations follow HAZARD_FWD_EN when defined.
module tb_hazard_ctl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;

    typedef struct {
        string      name;
        logic [8:0] v;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    exp_t e_cur;
    logic [8:0] act;

    hazard_ctl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif ();

    hazard_ctl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e_cur = exp_q.pop_front();
            act   = {hif.stall_fd, hif.flush_fd, hif.flush_de,
                     hif.fwd_a_sel, hif.fwd_b_sel, hif.stall_cnt};
            checks++;
            if (act !== e_cur.v) begin
                failures++;
                $display("FAIL %s: got st=%b ffd=%b fde=%b a=%b b=%b cnt=%0d, want st=%b ffd=%b fde=%b a=%b b=%b cnt=%0d",
                         e_cur.name, act[8], act[7], act[6], act[5:4], act[3:2], act[1:0],
                         e_cur.v[8], e_cur.v[7], e_cur.v[6], e_cur.v[5:4], e_cur.v[3:2], e_cur.v[1:0]);
            end
        end
    end

    // One clock of stimulus: decode fields, branch, clear, reset, then the expected outputs for this cycle.
    task automatic cyc(input string name, input logic v, input int rd, input int rs1, input logic u1,
                       input int rs2, input logic u2, input logic wen, input logic ld,
                       input logic br, input logic clr, input logic r,
                       input logic est, input logic effd, input logic efde,
                       input int ea, input int eb, input int ecnt);
        exp_t x;
        @(posedge clk);
        #1;
        rst             = r;
        hif.id_valid    = v;
        hif.id_rd       = REG_AW'(rd);
        hif.id_rs1      = REG_AW'(rs1);
        hif.id_rs1_used = u1;
        hif.id_rs2      = REG_AW'(rs2);
        hif.id_rs2_used = u2;
        hif.id_rd_wen   = wen;
        hif.id_is_load  = ld;
        hif.ex_br_taken = br;
        hif.cnt_clr     = clr;
        x.name = name;
        x.v    = {est, effd, efde, 2'(ea), 2'(eb), 2'(ecnt)};
        exp_q.push_back(x);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        hif.id_valid    = 1'b0;
        hif.id_rd       = '0;
        hif.id_rs1      = '0;
        hif.id_rs1_used = 1'b0;
        hif.id_rs2      = '0;
        hif.id_rs2_used = 1'b0;
        hif.id_rd_wen   = 1'b0;
        hif.id_is_load  = 1'b0;
        hif.ex_br_taken = 1'b0;
        hif.cnt_clr     = 1'b0;
        repeat (2) @(posedge clk);

`ifdef HAZARD_FWD_EN
        //    name            v rd rs1 u1 rs2 u2 wen ld br clr r  st ffd fde a b cnt
        cyc("reset",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t2_add_x5",      1, 5, 1, 1, 2, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t2_no_stall",    1, 6, 5, 1, 3, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t2_fwd_ex",      0, 0, 6, 1, 6, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
        cyc("t3_lw_x7",       1, 7, 1, 1, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t3_load_use",    1, 8, 7, 1, 7, 1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0);
        cyc("t3_release",     1, 8, 7, 1, 7, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("t3_fwd_mem",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 2, 1);
        cyc("t4_addi_x0",     1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("t4_add_x0",      1, 9, 0, 1, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("t4_sel_00",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("wb_add_x5",      1, 5, 1, 1, 2, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("wb_idle_a",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("wb_idle_b",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("wb_use",         1, 6, 5, 1, 3, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("wb_fwd_latch",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0, 1);
        cyc("pri_add_x5",     1, 5, 1, 1, 2, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("pri_add_x5b",    1, 5, 5, 1, 2, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("pri_use",        1, 6, 5, 1, 5, 1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1);
        cyc("pri_ex_wins",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1);
        cyc("t5_lw_x10",      1,10, 1, 1, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("t5_branch",      1,11,10, 1, 3, 1, 1, 0, 1, 0, 0,  0, 1, 1, 0, 0, 1);
        cyc("t5_bubble",      1,12,11, 1,11, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("t5_no_x11",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("t6_clr",         0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1);
        cyc("t6_lw_x7",       1, 7, 1, 1, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t6_stall1",      1, 8, 7, 1, 0, 0, 1, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0);
        cyc("t6_go1",         1, 8, 7, 1, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        cyc("t6_stall2",      1, 9, 8, 1, 0, 0, 1, 1, 0, 0, 0,  1, 0, 1, 2, 0, 1);
        cyc("t6_go2",         1, 9, 8, 1, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 2);
        cyc("t6_stall3",      1, 1, 9, 1, 9, 1, 1, 0, 0, 0, 0,  1, 0, 1, 2, 0, 2);
        cyc("t6_go3",         1, 1, 9, 1, 9, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
        cyc("t6_lw_x2",       1, 2, 1, 1, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 2, 2, 3);
        cyc("t6_stall4",      1, 3, 2, 1, 2, 1, 1, 0, 0, 0, 0,  1, 0, 1, 1, 0, 3);
        cyc("t6_saturated",   1, 3, 2, 1, 2, 1, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 3);
        cyc("t6_cleared",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 2, 0);
        cyc("t6_lw_x4",       1, 4, 1, 1, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t6_rst_mid",     1, 5, 4, 1, 4, 1, 1, 0, 0, 0, 1,  1, 0, 1, 0, 0, 0);
        cyc("t6_after_rst",   1, 5, 4, 1, 4, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t6_no_tracked",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
`else
        //    name            v rd rs1 u1 rs2 u2 wen ld br clr r  st ffd fde a b cnt
        cyc("reset",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t1_add_x5",      1, 5, 1, 1, 2, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t1_stall_ex",    1, 6, 5, 1, 3, 1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0);
        cyc("t1_stall_mem",   1, 6, 5, 1, 3, 1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1);
        cyc("t1_stall_wb",    1, 6, 5, 1, 3, 1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 2);
        cyc("t1_release",     1, 6, 5, 1, 3, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
        cyc("idvalid0_clr",   0, 0, 6, 1, 6, 1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 3);
        cyc("t4_addi_x0",     1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t4_add_x0",      1, 9, 0, 1, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t4_idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t5_add_x5",      1, 5, 1, 1, 2, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t5_branch",      1, 6, 5, 1, 3, 1, 1, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0);
        cyc("t5_bubble",      1,10, 6, 1, 6, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("unused_rs1",     1,11,10, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t6_add_x5",      1, 5, 1, 1, 2, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t6_stall_a",     1, 6, 5, 1, 3, 1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0);
        cyc("t6_stall_b",     1, 6, 5, 1, 3, 1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1);
        cyc("t6_stall_c",     1, 6, 5, 1, 3, 1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 2);
        cyc("t6_issue",       1, 6, 5, 1, 3, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
        cyc("t6_sat_rs2",     1, 7, 1, 1, 6, 1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3);
        cyc("t6_clr_stall",   1, 7, 1, 1, 6, 1, 1, 0, 0, 1, 0,  1, 0, 1, 0, 0, 3);
        cyc("t6_rst_mid",     1, 7, 1, 1, 6, 1, 1, 0, 0, 0, 1,  1, 0, 1, 0, 0, 0);
        cyc("t6_after_rst",   1, 7, 1, 1, 6, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        cyc("t6_idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
`endif

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
